// File: rtl/axi_2x1_rr_arbiter.sv
// Two-master round-robin grant arbiter for a shared AXI slave port.
// A grant is held until its read/write completion, or it is force-released after TIMEOUT cycles.
module axi_2x1_rr_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        aclk_0,
  input  logic        aresetn_0,
  input  logic        S00_req,
  input  logic        S01_req,
  input  logic        M00_rvalid,
  input  logic        M00_rready,
  input  logic        M00_rlast,
  input  logic        M00_bvalid,
  input  logic        M00_bready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,
  output logic        err_master,
  output logic [15:0] done_cnt_a,
  output logic [15:0] done_cnt_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  // Reset asserts immediately but is released only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge aclk_0 or negedge aresetn_0) begin
    if (!aresetn_0) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_e      state_q, state_d;
  logic        last_b_q, last_b_d;   // 1: master B was granted most recently
  logic [15:0] hold_q, hold_d;
  logic        timeout_d;
  logic        err_master_d;
  logic [15:0] done_a_d, done_b_d;
  logic        fin;

  assign fin = (M00_rvalid & M00_rready & M00_rlast) | (M00_bvalid & M00_bready);

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    last_b_d     = last_b_q;
    hold_d       = hold_q;
    timeout_d    = 1'b0;
    err_master_d = err_master;
    done_a_d     = done_cnt_a;
    done_b_d     = done_cnt_b;

    unique case (state_q)
      IDLE: begin
        if (S00_req && S01_req) state_d = last_b_q ? GNT_A : GNT_B;
        else if (S00_req)       state_d = GNT_A;
        else if (S01_req)       state_d = GNT_B;

        if (state_d != IDLE) begin
          hold_d   = '0;
          last_b_d = (state_d == GNT_B);
        end
      end

      GNT_A, GNT_B: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (fin) begin
          state_d = IDLE;
          if (state_q == GNT_A) begin
            if (done_cnt_a != CNT_MAX) done_a_d = done_cnt_a + 16'd1;
          end else begin
            if (done_cnt_b != CNT_MAX) done_b_d = done_cnt_b + 16'd1;
          end
        end else if (hold_q == HOLD_LAST) begin
          state_d      = IDLE;
          timeout_d    = 1'b1;
          err_master_d = (state_q == GNT_B);
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      hold_q      <= '0;
      grant       <= 2'b00;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_master  <= 1'b0;
      done_cnt_a  <= '0;
      done_cnt_b  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      hold_q      <= hold_d;
      grant       <= {state_d == GNT_B, state_d == GNT_A};
      busy        <= (state_d != IDLE);
      timeout_err <= timeout_d;
      err_master  <= err_master_d;
      done_cnt_a  <= done_a_d;
      done_cnt_b  <= done_b_d;
    end
  end

endmodule

// File: doc/axi_2x1_rr_arbiter.md
AXI_2X1_RR_ARBITER -- requirements
Module: axi_2x1_rr_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, is the maximum number of cycles one grant may be held before forced release (legal range 2..65535).
REQ-002 aclk_0  input  1  the single clock; all state updates on its rising edge.
REQ-003 aresetn_0  input  1  reset, asynchronous assertion, active-low.
REQ-004 S00_req  input  1  master A request (arvalid OR awvalid of master A).
REQ-005 S01_req  input  1  master B request (arvalid OR awvalid of master B).
REQ-006 M00_rvalid, M00_rready, M00_rlast  input  1 each  slave-side read data handshake.
REQ-007 M00_bvalid, M00_bready  input  1 each  slave-side write response handshake.
REQ-008 grant  output  2  one-hot grant: bit0 = master A, bit1 = master B, 2'b00 = none; drives the datapath mux select.
REQ-009 busy  output  1  high whenever grant != 2'b00.
REQ-010 timeout_err  output  1  one-cycle pulse on forced release.
REQ-011 err_master  output  1  master whose grant timed out (0 = A, 1 = B); holds until the next timeout.
REQ-012 done_cnt_a, done_cnt_b  output  16 each  completed transactions per master, saturating.

Function
REQ-013 States: IDLE, GNT_A, GNT_B; state and all outputs are registered; grant = 2'b01 in GNT_A, 2'b10 in GNT_B, 2'b00 in IDLE.
REQ-014 fin = (M00_rvalid & M00_rready & M00_rlast) | (M00_bvalid & M00_bready), evaluated combinationally each cycle.
REQ-015 IDLE, only one request high: the next state grants that requester.
REQ-016 IDLE, both requests high: the next state grants the master NOT recorded in last_grant; last_grant updates on every entry to GNT_x.
REQ-017 IDLE, no request: stay in IDLE.
REQ-018 Grant latency: request sampled high in IDLE -> grant asserted on the following cycle (one cycle).
REQ-019 GNT_x: grant is held regardless of request deassertion until fin or timeout; requests from the other master are ignored.
REQ-020 GNT_x with fin high: next state IDLE; done_cnt_x increments by 1, saturating at 16'hFFFF.
REQ-021 Every release passes through IDLE for at least one cycle; back-to-back grants are never issued without an IDLE cycle.
REQ-022 hold_cnt (16 bit) clears on entry to GNT_x and increments each granted cycle; on the TIMEOUT-th granted cycle, with fin low, the next state is IDLE.
REQ-023 On forced release, timeout_err = 1 for exactly the first IDLE cycle; err_master = released master; done_cnt is not incremented.
REQ-024 fin and the timeout condition in the same cycle: fin wins; normal release; no timeout_err.
REQ-025 A forced release counts as service: last_grant keeps the timed-out master, so the other master wins the next tie.

Reset
REQ-026 Asserting aresetn_0 low immediately (asynchronously) sets: state IDLE, grant 2'b00, busy 0, timeout_err 0, err_master 0, hold_cnt 0, done_cnt_a 0, done_cnt_b 0, last_grant = B (so master A wins the first tie).
REQ-027 Reset during GNT_x abandons the transaction with no counter update; deassertion is synchronized to aclk_0, and the first grant follows REQ-018 timing.

Verification
REQ-028 After reset, S00_req = S01_req = 1 at cycle 0 -> grant = 01 at cycle 1; fin at cycle 5 -> grant = 00 at cycle 6, grant = 10 at cycle 7, done_cnt_a = 1.
REQ-029 Both requests held continuously with fin every 4th granted cycle for 8 transactions -> grant alternates A,B,A,B...; done_cnt_a = done_cnt_b = 4.
REQ-030 TIMEOUT = 16, A granted, fin never asserted -> grant = 01 for exactly 16 cycles; then timeout_err = 1 for one cycle, err_master = 0, done_cnt_a unchanged.
REQ-031 TIMEOUT = 16, fin asserted on the 16th granted cycle -> normal release; timeout_err stays 0; done_cnt_a increments.
REQ-032 aresetn_0 dropped mid-GNT_B, asynchronously to the clock -> grant = 00 without waiting for a clock edge; all counters 0; after release, both requesting -> A granted first.
REQ-033 Force done_cnt_b = 16'hFFFE, complete 3 B transactions -> done_cnt_b = 16'hFFFF, no wrap.
